// File: rtl/hilo_muldiv_pkg.sv
// Shared opcodes and state types for the HI/LO multiply/divide unit.
// Slots 6/7 carry MADDU/MSUBU when the unit is built with HILO_MADD_EN.
package hilo_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADDU = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_PREP,
    DS_ITER,
    DS_FIX
  } div_state_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_e;

endpackage

// File: rtl/hilo_muldiv_unit_div.sv
// Restoring radix-2 divider: PREP takes magnitudes, ITER runs DW
// steps, FIX applies signs and the divide-by-zero result.
module hilo_div_iter
  import hilo_muldiv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          sgn,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [DW-1:0] rem
);
  localparam int CW = $clog2(DW);

  div_state_e    state;
  logic [DW-1:0] a_q, b_q, dvs, q_q, r_q;
  logic [DW-1:0] abs_a, abs_b;
  logic          sgn_q, neg_q, neg_r;
  logic [CW-1:0] cnt;
  logic [DW:0]   sh, diff;

  always_comb begin
    abs_a = (sgn_q && a_q[DW-1]) ? -a_q : a_q;
    abs_b = (sgn_q && b_q[DW-1]) ? -b_q : b_q;
    sh    = {r_q, q_q[DW-1]};
    diff  = sh - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= DS_IDLE;
    end else begin
      unique case (state)
        DS_IDLE: begin
          if (start) begin
            state <= DS_PREP;
            a_q   <= a;
            b_q   <= b;
            sgn_q <= sgn;
          end
        end
        DS_PREP: begin
          state <= DS_ITER;
          cnt   <= '0;
          q_q   <= abs_a;
          r_q   <= '0;
          dvs   <= abs_b;
          neg_q <= sgn_q & (a_q[DW-1] ^ b_q[DW-1]);
          neg_r <= sgn_q & a_q[DW-1];
        end
        DS_ITER: begin
          // keep the partial remainder only when it does not go negative
          if (!diff[DW]) begin
            r_q <= diff[DW-1:0];
            q_q <= {q_q[DW-2:0], 1'b1};
          end else begin
            r_q <= sh[DW-1:0];
            q_q <= {q_q[DW-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= DS_FIX;
        end
        DS_FIX: state <= DS_IDLE;
      endcase
    end
  end

  assign busy = (state != DS_IDLE);
  assign done = (state == DS_FIX);
  assign quot = (b_q == '0) ? '1  : (neg_q ? -q_q : q_q);
  assign rem  = (b_q == '0) ? a_q : (neg_r ? -r_q : r_q);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: pipelined multiply, iterative divide, MTHI/MTLO.
// Define HILO_MADD_EN to add the MADDU/MSUBU accumulate stage.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);
  localparam int PW = 2 * DW;
  localparam int ML = MUL_STAGES - 1;

  logic                  accept, is_mul, is_div, sgn;
  logic                  wr_hi, wr_lo;
  logic [PW-1:0]         op_a, op_b, prod;
  logic [MUL_STAGES-1:0] mul_v;
  logic [PW-1:0]         mul_p [MUL_STAGES];
  logic                  mul_wr, acc_v;
  logic [PW-1:0]         mul_res;
  logic                  div_busy, div_done;
  logic [DW-1:0]         div_q, div_r;
  logic [DW-1:0]         hi_q, lo_q;
  logic                  done_q;
`ifdef HILO_MADD_EN
  acc_e                  acc_k;
`endif

  assign busy      = (|mul_v) | acc_v | div_busy;
  assign req_ready = ~busy;
  assign accept    = req_valid & req_ready & ~flush;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign done      = done_q;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
`ifdef HILO_MADD_EN
    acc_k  = ACC_NONE;
`endif
    unique case (1'b1)
      req_op == OP_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
      req_op == OP_MULTU: is_mul = 1'b1;
      req_op == OP_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
      req_op == OP_DIVU:  is_div = 1'b1;
      req_op == OP_MTHI:  wr_hi = 1'b1;
      req_op == OP_MTLO:  wr_lo = 1'b1;
`ifdef HILO_MADD_EN
      req_op == OP_MADDU: begin is_mul = 1'b1; acc_k = ACC_ADD; end
      req_op == OP_MSUBU: begin is_mul = 1'b1; acc_k = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  // extend to 2*DW so the low half of one product covers both signednesses
  assign op_a = {{DW{sgn & req_a[DW-1]}}, req_a};
  assign op_b = {{DW{sgn & req_b[DW-1]}}, req_b};
  assign prod = op_a * op_b;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mul_v <= '0;
    end else begin
      mul_v[0] <= accept & is_mul;
      for (int i = 1; i < MUL_STAGES; i++) mul_v[i] <= mul_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    mul_p[0] <= prod;
    for (int i = 1; i < MUL_STAGES; i++) mul_p[i] <= mul_p[i-1];
  end

`ifdef HILO_MADD_EN
  acc_e          mul_k [MUL_STAGES];
  logic [PW-1:0] acc_p;

  always_ff @(posedge clk) begin
    mul_k[0] <= acc_k;
    for (int i = 1; i < MUL_STAGES; i++) mul_k[i] <= mul_k[i-1];
    if (mul_k[ML] == ACC_SUB) acc_p <= {hi_q, lo_q} - mul_p[ML];
    else                      acc_p <= {hi_q, lo_q} + mul_p[ML];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) acc_v <= 1'b0;
    else acc_v <= mul_v[ML] & (mul_k[ML] != ACC_NONE);
  end

  assign mul_wr  = (mul_v[ML] & (mul_k[ML] == ACC_NONE)) | acc_v;
  assign mul_res = acc_v ? acc_p : mul_p[ML];
`else
  assign acc_v   = 1'b0;
  assign mul_wr  = mul_v[ML];
  assign mul_res = mul_p[ML];
`endif

  hilo_div_iter #(
    .DW(DW)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(accept & is_div),
    .abort(flush),
    .sgn  (sgn),
    .a    (req_a),
    .b    (req_b),
    .busy (div_busy),
    .done (div_done),
    .quot (div_q),
    .rem  (div_r)
  );

  // only one op is ever in flight, so the write sources never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!flush) begin
        if (mul_wr) begin
          {hi_q, lo_q} <= mul_res;
          done_q       <= 1'b1;
        end else if (div_done) begin
          hi_q   <= div_r;
          lo_q   <= div_q;
          done_q <= 1'b1;
        end else if (accept) begin
          if (wr_hi) hi_q <= req_a;
          if (wr_lo) lo_q <= req_a;
        end
      end
    end
  end

endmodule
